// File: rtl/crc_stream_controller.sv
// Sequencer for the CRC datapath: queues encode/check requests and walks each one
// through a load cycle, SHIFT_CYCLES shift cycles and a one-cycle completion strobe.
module crc_stream_controller #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  CRC_WIDTH      = 8,
    parameter int  BITS_PER_CYCLE = 1,
    parameter int  QUEUE_DEPTH    = 2,
    localparam int SHIFT_CYCLES   = (DATA_WIDTH + CRC_WIDTH) / BITS_PER_CYCLE,
    localparam int CW             = ($clog2(SHIFT_CYCLES) > 1) ? $clog2(SHIFT_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          write,
    input  logic          mode,
    input  logic          crc_zero,
    output logic          load_en,
    output logic          shift_en,
    output logic [CW-1:0] shift_index,
    output logic          data_valid,
    output logic          check_valid,
    output logic          check_fail,
    output logic          overflow,
    output logic          queue_full,
    output logic          controller_busy
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QW = $clog2(QUEUE_DEPTH + 1);

    if ((DATA_WIDTH + CRC_WIDTH) % BITS_PER_CYCLE != 0) begin : g_bad_bpc
        $error("DATA_WIDTH+CRC_WIDTH must be a multiple of BITS_PER_CYCLE");
    end
    if (QUEUE_DEPTH < 1) begin : g_bad_depth
        $error("QUEUE_DEPTH must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 cur_mode_q, cur_mode_d;
    logic [QUEUE_DEPTH-1:0] fifo_q;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [QW-1:0]        count_q, count_d;
    logic                 load_q, shift_q, dv_q, cv_q, ovf_q, full_q, busy_q;
    logic [CW-1:0]        idx_q, idx_d;
    logic                 push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pop happens only when a new operation starts; a pop frees a slot for a same-cycle push.
    always_comb begin
        pop        = ((state_q == IDLE) || (state_q == DONE)) && (count_q != '0);
        push       = write && ((count_q != QW'(QUEUE_DEPTH)) || pop);
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_mode_d = cur_mode_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d    = count_q + QW'(push) - QW'(pop);

        unique case (state_q)
            IDLE, DONE: begin
                if (pop) begin
                    state_d    = LOAD;
                    cur_mode_d = fifo_q[rd_ptr_q];
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                if (cnt_q == CW'(SHIFT_CYCLES - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        idx_d = (state_d == SHIFT) ? cnt_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_mode_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            idx_q      <= '0;
            dv_q       <= 1'b0;
            cv_q       <= 1'b0;
            ovf_q      <= 1'b0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_mode_q <= cur_mode_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            load_q     <= (state_d == LOAD);
            shift_q    <= (state_d == SHIFT);
            idx_q      <= idx_d;
            dv_q       <= (state_d == DONE) && !cur_mode_d;
            cv_q       <= (state_d == DONE) && cur_mode_d;
            ovf_q      <= write && !push;
            full_q     <= (count_d == QW'(QUEUE_DEPTH));
            busy_q     <= (state_d != IDLE) || (count_d != '0);
        end
    end

    // Queue storage holds only mode bits; occupancy is tracked by count_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mode;
        end
    end

    assign load_en         = load_q;
    assign shift_en        = shift_q;
    assign shift_index     = idx_q;
    assign data_valid      = dv_q;
    assign check_valid     = cv_q;
    assign check_fail      = cv_q & ~crc_zero;
    assign overflow        = ovf_q;
    assign queue_full      = full_q;
    assign controller_busy = busy_q;

endmodule

// File: tb/tb_crc_stream_controller.sv
// Scoreboard bench for crc_stream_controller: a request-level schedule model predicts
// load/shift/strobe cycles, drops, busy and full; a negedge monitor compares every cycle.
`timescale 1ns/1ps
module tb_crc_stream_controller;

    localparam int S  = 12;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic write = 1'b0, mode = 1'b0, crc_zero = 1'b0;
    logic load_en, shift_en, data_valid, check_valid, check_fail;
    logic overflow, queue_full, controller_busy;
    logic [3:0] shift_index;

    logic write4 = 1'b0, mode4 = 1'b0, crc_zero4 = 1'b0;
    logic load_en4, shift_en4, data_valid4, check_valid4, check_fail4;
    logic overflow4, queue_full4, controller_busy4;
    logic [1:0] shift_index4;

    crc_stream_controller #(
        .DATA_WIDTH(8), .CRC_WIDTH(4), .BITS_PER_CYCLE(1), .QUEUE_DEPTH(QD)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .write(write), .mode(mode), .crc_zero(crc_zero),
        .load_en(load_en), .shift_en(shift_en), .shift_index(shift_index),
        .data_valid(data_valid), .check_valid(check_valid), .check_fail(check_fail),
        .overflow(overflow), .queue_full(queue_full), .controller_busy(controller_busy)
    );

    crc_stream_controller #(
        .DATA_WIDTH(8), .CRC_WIDTH(4), .BITS_PER_CYCLE(4), .QUEUE_DEPTH(QD)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .write(write4), .mode(mode4), .crc_zero(crc_zero4),
        .load_en(load_en4), .shift_en(shift_en4), .shift_index(shift_index4),
        .data_valid(data_valid4), .check_valid(check_valid4), .check_fail(check_fail4),
        .overflow(overflow4), .queue_full(queue_full4), .controller_busy(controller_busy4)
    );

    always #5 clk = ~clk;

    int cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int acc;
        int ld;
        int st;
        bit m;
    } rec_t;

    rec_t recs[$];
    rec_t sb[$];
    int   ovfq[$];
    int   last_st;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int outvec();
        return int'({load_en, shift_en, shift_index, data_valid, check_valid, check_fail,
                     overflow, queue_full, controller_busy});
    endfunction

    task automatic model_clear();
        recs.delete();
        sb.delete();
        ovfq.delete();
        last_st = -1000;
    endtask

    // Request sampled at edge k: accepted if a slot is free or a queued one starts at k.
    task automatic model_req(input int k, input bit m);
        int   q;
        bit   popping;
        rec_t r;
        q = 0;
        popping = 1'b0;
        foreach (recs[i]) begin
            if (recs[i].acc < k && recs[i].ld >= k) q++;
            if (recs[i].ld == k) popping = 1'b1;
        end
        if (q < QD || popping) begin
            r.acc = k;
            r.ld  = (k + 1 > last_st + 1) ? k + 1 : last_st + 1;
            r.st  = r.ld + 1 + S;
            r.m   = m;
            last_st = r.st;
            recs.push_back(r);
            sb.push_back(r);
        end else begin
            ovfq.push_back(k);
        end
    endtask

    task automatic issue(input bit w, input bit m, input bit z);
        write = w;
        mode = m;
        crc_zero = z;
        if (w) model_req(cyc + 1, m);
        @(posedge clk);
        #1;
    endtask

    int         c, nq;
    bit         el, es, edv, ecv, ecf, eo, eb;
    logic [3:0] ei;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out", outvec(), 0);
        end else if (cyc >= 0) begin
            c = cyc;
            el = 0; es = 0; ei = '0; edv = 0; ecv = 0; ecf = 0;
            if (sb.size() > 0) begin
                if (c == sb[0].ld) el = 1;
                else if (c > sb[0].ld && c <= sb[0].ld + S) begin
                    es = 1;
                    ei = 4'(c - sb[0].ld - 1);
                end else if (c == sb[0].st) begin
                    edv = !sb[0].m;
                    ecv = sb[0].m;
                    ecf = sb[0].m & ~crc_zero;
                end
            end
            check("ctrl", int'({load_en, shift_en, shift_index, data_valid, check_valid, check_fail}),
                  int'({el, es, ei, edv, ecv, ecf}));
            if (sb.size() > 0 && c >= sb[0].st) void'(sb.pop_front());

            eo = (ovfq.size() > 0 && ovfq[0] == c);
            if (eo) void'(ovfq.pop_front());
            check("overflow", int'(overflow), int'(eo));

            eb = 0;
            nq = 0;
            foreach (recs[i]) begin
                if (recs[i].acc <= c && c <= recs[i].st) eb = 1;
                if (recs[i].acc <= c && recs[i].ld > c) nq++;
            end
            check("busy", int'(controller_busy), int'(eb));
            check("queue_full", int'(queue_full), int'(nq == QD));
        end
    end

    initial begin : t_bpc4
        int ld, nsh, cvc;
        ld = -1;
        nsh = 0;
        cvc = -1;
        @(posedge rst_n);
        @(posedge clk);
        #1;
        write4 = 1'b1; mode4 = 1'b1; crc_zero4 = 1'b1;
        @(posedge clk);
        #1;
        write4 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (load_en4) ld = i;
            if (shift_en4) begin
                check("bpc4_idx", int'(shift_index4), nsh);
                nsh++;
            end
            if (check_valid4) begin
                cvc = i;
                check("bpc4_fail", int'(check_fail4), 0);
            end
            check("bpc4_dv", int'(data_valid4), 0);
        end
        check("bpc4_nshift", nsh, 3);
        check("bpc4_lat", cvc - ld, 4);
    end

    initial begin : t_main
        bit found;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(1, 0, 1);
        repeat (20) issue(0, 0, 1);

        issue(1, 0, 0);
        issue(1, 1, 0);
        repeat (35) issue(0, 0, 0);

        repeat (4) issue(1, 1'($urandom % 2), 1'($urandom % 2));
        repeat (60) issue(0, 0, 1'($urandom % 2));

        repeat (40) issue(1, 1'($urandom % 2), 1'($urandom % 2));
        repeat (1500) issue(($urandom % 5) == 0, 1'($urandom % 2), 1'($urandom % 2));
        repeat (150) issue(0, 0, 1'($urandom % 2));

        issue(1, 0, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (shift_en && shift_index == 4'd5) found = 1'b1;
            else issue(0, 0, 1);
        end
        check("find_shift5", int'(found), 1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_rst", outvec(), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(1, 1, 0);
        for (int i = 0; i < 300 && (sb.size() > 0 || ovfq.size() > 0); i++) issue(0, 0, 0);
        repeat (5) issue(0, 0, 0);
        check("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
